// File: rtl/sm_mult_pkg.sv
// sm_mult_pkg: shared state encoding and width helpers for the sign-magnitude multiplier
package sm_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operand width: magnitude bits plus one sign bit
    function automatic int op_w(input int mag_w);
        return mag_w + 1;
    endfunction

    // Product width: double-width magnitude plus one sign bit
    function automatic int prod_w(input int mag_w);
        return 2 * mag_w + 1;
    endfunction

    // Step counter width, wide enough to hold 0..mag_w
    function automatic int cnt_w(input int mag_w);
        return $clog2(mag_w + 1);
    endfunction

endpackage

// File: rtl/sm_mult_shift_add.sv
// sm_mult_shift_add: shift-and-add magnitude datapath, one multiplier bit per step
module sm_mult_shift_add
    import sm_mult_pkg::*;
#(
    parameter int MAG_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [MAG_W-1:0]     mcand_i,
    input  logic [MAG_W-1:0]     mplier_i,
    output logic [2*MAG_W-1:0]   acc_nxt_o,
    output logic                 last_o
);

    localparam int PW = 2 * MAG_W;
    localparam int CW = cnt_w(MAG_W);

    logic [MAG_W-1:0] mcand_q, mcand_d;
    logic [MAG_W-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_nxt;

    // Partial product for the current multiplier bit and next-state selection
    always_comb begin
        addend    = mplier_q[0] ? ({{MAG_W{1'b0}}, mcand_q} << cnt_q) : '0;
        acc_nxt   = acc_q + addend;
        mcand_d   = load_i ? mcand_i : mcand_q;
        mplier_d  = load_i ? mplier_i : step_i ? (mplier_q >> 1) : mplier_q;
        cnt_d     = load_i ? '0 : step_i ? cnt_q + CW'(1) : cnt_q;
        acc_d     = load_i ? '0 : step_i ? acc_nxt : acc_q;
        last_o    = (cnt_q == CW'(MAG_W - 1));
        acc_nxt_o = acc_nxt;
    end

    // Datapath registers; an asynchronous reset clears any in-flight work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/sm_seq_multiplier.sv
// sm_seq_multiplier: sequential sign-magnitude multiplier with start/ready/done handshake
module sm_seq_multiplier
    import sm_mult_pkg::*;
#(
    parameter int MAG_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [op_w(MAG_W)-1:0]       A,
    input  logic [op_w(MAG_W)-1:0]       B,
    output logic                         ready,
    output logic                         done,
    output logic [prod_w(MAG_W)-1:0]     Product,
    output logic                         ZF,
    output logic                         SF
);

    localparam int PW = prod_w(MAG_W);

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [PW-1:0]        product_q, product_d;
    logic                 zf_q, zf_d;
    logic                 sf_q, sf_d;
    logic                 done_q, done_d;
    logic                 load, step, last, fin, res_zf;
    logic [2*MAG_W-1:0]   acc_nxt;

    sm_mult_shift_add #(.MAG_W(MAG_W)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .mcand_i   (A[MAG_W-1:0]),
        .mplier_i  (B[MAG_W-1:0]),
        .acc_nxt_o (acc_nxt),
        .last_o    (last)
    );

    // Next state and datapath control
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                load    = start;
                state_d = start ? BUSY : IDLE;
            end
            BUSY: begin
                step    = 1'b1;
                state_d = last ? DONE : BUSY;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result formation; a zero magnitude always carries a positive sign
    always_comb begin
        fin       = step & last;
        res_zf    = ~|acc_nxt;
        sign_d    = load ? (A[MAG_W] ^ B[MAG_W]) : sign_q;
        product_d = fin ? {sign_q & ~res_zf, acc_nxt} : product_q;
        zf_d      = fin ? res_zf : zf_q;
        sf_d      = fin ? (sign_q & ~res_zf) : sf_q;
        done_d    = fin;
    end

    // State and output registers; outputs hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            product_q <= '0;
            zf_q      <= 1'b1;
            sf_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            zf_q      <= zf_d;
            sf_q      <= sf_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign Product = product_q;
    assign ZF      = zf_q;
    assign SF      = sf_q;

endmodule
